hier_status_collector: RTL and testbench

- Bottom-up counterpart to the generated top-down instance tree: a parent fans out to NUM_CHILDREN sub-instances, and this block gathers their reports back up.
- Collects status words from NUM_CHILDREN child ports with valid/ready handshakes.
- Arbitrates round-robin, buffers each winning word with its source index in a small FIFO, and forwards it to the parent over one valid/ready port.
- Tracks which children have reported, for hierarchy-completion checks in the test trees.

---
 rtl/hier_collect_pkg.sv | 21 ++
 rtl/hier_status_collector_rr_arbiter.sv | 35 +++
 rtl/hier_status_collector.sv | 99 +++++++++
 tb/tb_hier_status_collector.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hier_collect_pkg.sv
// Shared constants, width helper and entry type for the hierarchy status collector.
package hier_collect_pkg;

  localparam int DEF_NUM_CHILDREN = 5;
  localparam int DEF_DATA_W       = 8;
  localparam int DEF_FIFO_DEPTH   = 4;

  // Source-index width: clog2 of the child count, never narrower than one bit.
  function automatic int src_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_SRC_W = src_width(DEF_NUM_CHILDREN);

  // Buffered report at default widths; the collector redeclares it at its own widths.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_SRC_W-1:0]  src;
  } collect_entry_t;

endpackage

// File: rtl/hier_status_collector_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr wins, wrapping.
module rr_arbiter
  import hier_collect_pkg::*;
#(
  parameter  int N  = DEF_NUM_CHILDREN,
  localparam int IW = src_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic          enable,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid
);

  // Scan N positions starting at ptr; the first active request takes the grant.
  always_comb begin
    logic [IW-1:0] idx;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = '0;
    if (enable) begin
      for (int k = 0; k < N; k++) begin
        idx = IW'((int'(ptr) + k) % N);
        if (!gnt_valid && req[idx]) begin
          gnt[idx]  = 1'b1;
          gnt_idx   = idx;
          gnt_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hier_status_collector.sv
// Gathers child status words round-robin into a small FIFO and forwards them upward,
// tracking which children have reported at least once.
module hier_status_collector
  import hier_collect_pkg::*;
#(
  parameter  int NUM_CHILDREN = DEF_NUM_CHILDREN,
  parameter  int DATA_W       = DEF_DATA_W,
  parameter  int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  localparam int SRC_W        = src_width(NUM_CHILDREN)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CHILDREN-1:0]        child_valid,
  input  logic [NUM_CHILDREN*DATA_W-1:0] child_data,
  output logic [NUM_CHILDREN-1:0]        child_ready,
  output logic                           up_valid,
  output logic [DATA_W-1:0]              up_data,
  output logic [SRC_W-1:0]               up_src,
  input  logic                           up_ready,
  input  logic                           clear,
  output logic [NUM_CHILDREN-1:0]        done_mask,
  output logic                           all_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [SRC_W-1:0]  src;
  } entry_t;

  entry_t                  mem [FIFO_DEPTH];
  entry_t                  head;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count, count_next;
  logic [SRC_W-1:0]        rr_ptr, gnt_idx;
  logic [NUM_CHILDREN-1:0] gnt, done_next;
  logic                    gnt_valid, arb_en, push, pop;
  logic [DATA_W-1:0]       cdata [NUM_CHILDREN];

  for (genvar i = 0; i < NUM_CHILDREN; i++) begin : g_unpack
    assign cdata[i] = child_data[i*DATA_W +: DATA_W];
  end

  // Grant only while there is room; up_ready deliberately plays no part here.
  assign arb_en = (count < CW'(FIFO_DEPTH)) && !rst;

  rr_arbiter #(.N(NUM_CHILDREN)) u_arb (
    .req       (child_valid),
    .enable    (arb_en),
    .ptr       (rr_ptr),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  assign child_ready = gnt;
  assign push        = gnt_valid;
  assign up_valid    = (count != '0);
  assign pop         = up_valid && up_ready;
  assign head        = mem[rd_ptr];
  // Stale storage is masked so the head reads as zero whenever the FIFO is empty.
  assign up_data     = up_valid ? head.data : '0;
  assign up_src      = up_valid ? head.src  : '0;

  // Next-state of occupancy and the sticky report mask; clear beats a same-cycle accept.
  always_comb begin
    count_next = count + CW'(push) - CW'(pop);
    done_next  = clear ? '0 : (done_mask | gnt);
  end

  // FIFO pointers, round-robin pointer and completion flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rr_ptr    <= '0;
      done_mask <= '0;
      all_done  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        rr_ptr <= (gnt_idx == SRC_W'(NUM_CHILDREN - 1)) ? '0 : gnt_idx + SRC_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count     <= count_next;
      done_mask <= done_next;
      all_done  <= (&done_next) && (count_next == '0);
    end
  end

  // Entry storage needs no reset: it is only visible through up_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{data: cdata[gnt_idx], src: gnt_idx};
  end

endmodule

// File: tb/tb_hier_status_collector.sv
// Directed bench: per-child word queues drive the child ports with a legal hold-until-ready
// protocol, tests push hand-computed expected words, and a monitor checks every pop.
module tb_hier_status_collector;

  localparam int NC = 5;
  localparam int DW = 8;
  localparam int SW = 3;

  logic             clk = 1'b0;
  logic             rst, clear, up_ready;
  logic [NC-1:0]    child_valid, child_ready, done_mask;
  logic [NC*DW-1:0] child_data;
  logic             up_valid, all_done;
  logic [DW-1:0]    up_data;
  logic [SW-1:0]    up_src;

  int checks = 0;
  int fails  = 0;

  logic [SW+DW-1:0] exp_q [$];
  logic [SW+DW-1:0] e;
  logic [DW-1:0]    cw [NC][16];
  int               hd [NC];
  int               tl [NC];
  logic [NC-1:0]    hs;
  logic [NC-1:0]    pend = '0;
  logic [NC*DW-1:0] pdata = '0;

  always #5 clk = ~clk;

  hier_status_collector #(.NUM_CHILDREN(NC), .DATA_W(DW), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .child_valid (child_valid),
    .child_data  (child_data),
    .child_ready (child_ready),
    .up_valid    (up_valid),
    .up_data     (up_data),
    .up_src      (up_src),
    .up_ready    (up_ready),
    .clear       (clear),
    .done_mask   (done_mask),
    .all_done    (all_done)
  );

  // Children present the head of their queue until it is accepted.
  always_comb begin
    child_valid = '0;
    child_data  = '0;
    for (int i = 0; i < NC; i++) begin
      if (hd[i] < tl[i]) begin
        child_valid[i]          = 1'b1;
        child_data[i*DW +: DW]  = cw[i][hd[i]];
      end
    end
  end

  always @(negedge clk) hs = child_valid & child_ready;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NC; i++) if (hs[i]) hd[i]++;
  end

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Scoreboard monitor: every delivered word must match the next expected one.
  always @(negedge clk) begin
    if (!rst && up_valid && up_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_pop: got src=%0d data=%0h expected none", up_src, up_data);
      end else begin
        e = exp_q.pop_front();
        chk("pop_src", int'(up_src), int'(e[DW +: SW]));
        chk("pop_data", int'(up_data), int'(e[DW-1:0]));
      end
    end
  end

  // Child protocol: a word offered but not taken must be held unchanged.
  always @(negedge clk) begin
    for (int i = 0; i < NC; i++) begin
      if (pend[i] && !rst)
        assert (child_valid[i] && child_data[i*DW +: DW] == pdata[i*DW +: DW])
          else $error("child %0d dropped its word before ready", i);
    end
    pend  = child_valid & ~child_ready;
    pdata = child_data;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic put(input int c, input logic [DW-1:0] d);
    cw[c][tl[c]] = d;
    tl[c]++;
  endtask

  task automatic expect_word(input int s, input int d);
    exp_q.push_back({SW'(s), DW'(d)});
  endtask

  task automatic drain();
    int n;
    n = 0;
    up_ready = 1'b1;
    while ((exp_q.size() != 0 || up_valid) && n < 40) begin
      tick();
      n++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_up_valid", int'(up_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clear = 1'b0; up_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_up_valid", int'(up_valid), 0);
    chk("rst_child_ready", int'(child_ready), 0);
    chk("rst_done_mask", int'(done_mask), 0);
    chk("rst_all_done", int'(all_done), 0);
    chk("rst_up_data", int'(up_data), 0);
    rst = 1'b0;
    tick();
    chk("idle_up_valid", int'(up_valid), 0);
    chk("idle_child_ready", int'(child_ready), 0);

    // Reset in the middle of a burst of three buffered words.
    put(0, 8'hA0); put(1, 8'hA1); put(2, 8'hA2);
    #1;
    chk("burst_first_grant", int'(child_ready), 5'b00001);
    repeat (3) tick();
    chk("burst_up_valid", int'(up_valid), 1);
    chk("burst_head_src", int'(up_src), 0);
    chk("burst_head_data", int'(up_data), 8'hA0);
    chk("burst_done_mask", int'(done_mask), 5'b00111);
    rst = 1'b1;
    #1;
    chk("midrst_up_valid", int'(up_valid), 0);
    chk("midrst_done_mask", int'(done_mask), 0);
    chk("midrst_child_ready", int'(child_ready), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("postrst_up_valid", int'(up_valid), 0);

    // All children at once, parent always ready: in-order, one-cycle latency.
    for (int i = 0; i < NC; i++) begin
      put(i, DW'(8'h10 + i));
      expect_word(i, 8'h10 + i);
    end
    up_ready = 1'b1;
    #1;
    chk("all_first_grant", int'(child_ready), 5'b00001);
    for (int k = 1; k <= NC; k++) begin
      tick();
      chk("all_latency_valid", int'(up_valid), 1);
      chk("all_latency_src", int'(up_src), k - 1);
    end
    chk("all_done_mask", int'(done_mask), 5'b11111);
    chk("all_done_early", int'(all_done), 0);
    tick();
    chk("all_drained", int'(up_valid), 0);
    chk("all_done_set", int'(all_done), 1);

    // Fairness: children 1 and 3 contend continuously from ptr 0.
    for (int k = 0; k < 4; k++) begin
      put(1, DW'(8'h20 + k));
      put(3, DW'(8'h30 + k));
    end
    for (int k = 0; k < 4; k++) begin
      expect_word(1, 8'h20 + k);
      expect_word(3, 8'h30 + k);
    end
    #1;
    chk("rr_grant_1", int'(child_ready), 5'b00010);
    tick();
    chk("rr_grant_3", int'(child_ready), 5'b01000);
    drain();

    // Pointer now sits at 4; a lone request from child 0 must wrap around to it.
    put(0, 8'h40);
    expect_word(0, 8'h40);
    #1;
    chk("wrap_grant_0", int'(child_ready), 5'b00001);
    drain();
    put(4, 8'h41);
    expect_word(4, 8'h41);
    drain();

    // Backpressure: four accepts fill the FIFO, then nothing until a pop.
    up_ready = 1'b0;
    for (int i = 0; i < NC; i++) begin
      put(i, DW'(8'h50 + i));
      expect_word(i, 8'h50 + i);
    end
    repeat (4) tick();
    chk("bp_full_no_grant", int'(child_ready), 0);
    chk("bp_head_src", int'(up_src), 0);
    chk("bp_head_data", int'(up_data), 8'h50);
    repeat (2) tick();
    chk("bp_hold_no_grant", int'(child_ready), 0);
    chk("bp_hold_data", int'(up_data), 8'h50);
    up_ready = 1'b1;
    tick();
    up_ready = 1'b0;
    chk("bp_after_pop_grant", int'(child_ready), 5'b10000);
    chk("bp_after_pop_src", int'(up_src), 1);
    tick();
    chk("bp_refill_head", int'(up_src), 1);
    drain();

    // Three buffered, then push and pop on the same edge keep occupancy at three.
    up_ready = 1'b0;
    put(0, 8'h60); put(1, 8'h61); put(2, 8'h62);
    for (int i = 0; i < NC; i++) expect_word(i, 8'h60 + i);
    repeat (3) tick();
    put(3, 8'h63);
    up_ready = 1'b1;
    #1;
    chk("pp_grant_3", int'(child_ready), 5'b01000);
    tick();
    up_ready = 1'b0;
    put(4, 8'h64);
    #1;
    chk("pp_count_kept", int'(child_ready), 5'b10000);
    chk("pp_head_src", int'(up_src), 1);
    tick();
    chk("pp_head_data", int'(up_data), 8'h61);
    drain();

    // clear on the same edge as child 2's accept leaves its bit low; word still flows.
    up_ready = 1'b0;
    put(2, 8'h70);
    expect_word(2, 8'h70);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_done_mask", int'(done_mask), 0);
    chk("clr_up_src", int'(up_src), 2);
    chk("clr_up_data", int'(up_data), 8'h70);
    chk("clr_all_done", int'(all_done), 0);
    put(1, 8'h71);
    expect_word(1, 8'h71);
    tick();
    chk("clr_then_accept", int'(done_mask), 5'b00010);
    drain();
    chk("end_all_done", int'(all_done), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
